// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants.
// Holds load/store Funct3 encodings and the default data memory depth.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DMEM_DEPTH_WORDS = 256;

endpackage

// File: rtl/data_memory_load_extend.sv
// Load lane select and sign/zero extension for the data memory.
// Ports: word (array word), a_lo (A[1:0]), funct3, en (load enable), rd (load data).
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  a_lo,
    input  logic [2:0]  funct3,
    input  logic        en,
    output logic [31:0] rd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*a_lo +: 8];
        half_sel = a_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        rd = '0;
        if (en) begin
            case (funct3)
                F3_B:    rd = {{24{byte_sel[7]}}, byte_sel};
                F3_H:    rd = {{16{half_sel[15]}}, half_sel};
                F3_W:    rd = word;
                F3_BU:   rd = {24'd0, byte_sel};
                F3_HU:   rd = {16'd0, half_sel};
                default: rd = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// Single-cycle data memory: combinational loads, byte-lane stores, fault capture.
// Ports: clk, rst_n, A (byte addr), WD, WE, RE, Funct3 -> RD, Fault, ErrSticky, ErrAddr.
module data_memory
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic        RE,
    input  logic [2:0]  Funct3,
    output logic [31:0] RD,
    output logic        Fault,
    output logic        ErrSticky,
    output logic [31:0] ErrAddr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          illegal;
    logic          misalign;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          wr_en;
    logic          rd_en;
    logic          err_q;
    logic [31:0]   err_addr_q;

    assign idx = A[AW+1:2];

    // Unsigned widths have no store form, so they are illegal with WE.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (Funct3)
            F3_B:    illegal = 1'b0;
            F3_H:    misalign = A[0];
            F3_W:    misalign = |A[1:0];
            F3_BU:   illegal = WE;
            F3_HU: begin
                illegal  = WE;
                misalign = A[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign Fault = (WE | RE) & (illegal | misalign);

    always_comb begin
        be    = 4'b0000;
        wdata = WD;
        case (Funct3)
            F3_B: begin
                be    = 4'b0001 << A[1:0];
                wdata = {4{WD[7:0]}};
            end
            F3_H: begin
                be    = A[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WD[15:0]}};
            end
            F3_W: begin
                be    = 4'b1111;
                wdata = WD;
            end
            default: be = 4'b0000;
        endcase
    end

    assign wr_en = WE & ~Fault;
    assign rd_en = RE & ~Fault & ~illegal & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Only the first fault after reset is recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (Fault && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= A;
        end
    end

    load_extend u_load_extend (
        .word   (mem_q[idx]),
        .a_lo   (A[1:0]),
        .funct3 (Funct3),
        .en     (rd_en),
        .rd     (RD)
    );

    assign ErrSticky = err_q;
    assign ErrAddr   = err_addr_q;

endmodule
